// File: rtl/syscall_string_printer_if.sv
// Bus between the pipeline/data-memory side and the print-string syscall stage.
interface syscall_string_printer_if;
  logic        syscall_control;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        sysstall;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        done;

  // Pipeline and memory side: issues the syscall, returns read data.
  modport master (
    output syscall_control, v0, a0, mem_data,
    input  mem_rd, mem_addr, sysstall, char_valid, char_out, done
  );

  // Printer side.
  modport slave (
    input  syscall_control, v0, a0, mem_data,
    output mem_rd, mem_addr, sysstall, char_valid, char_out, done
  );
endinterface

// File: rtl/syscall_string_printer.sv
// Print-string syscall stage: fetches a NUL-terminated string from data memory
// and emits it one byte per cycle while stalling the pipeline.
module syscall_string_printer #(
  parameter int unsigned MAX_LEN   = 256,
  parameter bit          SIM_PRINT = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  syscall_string_printer_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StEmit, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [31:0]     r_ptr;
  logic [31:0]     r_word;
  logic [CntW-1:0] r_count;
  logic            r_armed;

  logic            w_trigger;
  logic [7:0]      w_byte;
  logic [CntW-1:0] w_count_inc;
  logic            w_emit;

  assign w_trigger   = (r_state == StIdle) && bus.syscall_control && (bus.v0 == 32'd4) && r_armed;
  // Little-endian byte lane selected by the low pointer bits.
  assign w_byte      = 8'(r_word >> {r_ptr[1:0], 3'b000});
  assign w_count_inc = r_count + 1'b1;
  assign w_emit      = (r_state == StEmit) && (w_byte != 8'h00);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_word  <= '0;
      r_count <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_next;
      // Re-arm only once the syscall has been released, so a held one never restarts.
      if (!bus.syscall_control) begin
        r_armed <= 1'b1;
      end else if (w_trigger) begin
        r_armed <= 1'b0;
      end
      if (w_trigger) begin
        r_ptr   <= bus.a0;
        r_count <= '0;
      end else if (w_emit) begin
        r_ptr   <= r_ptr + 32'd1;
        r_count <= w_count_inc;
      end
      if (r_state == StWait) begin
        r_word <= bus.mem_data;
      end
    end
  end

  // Next-state decode and outputs.
  always_comb begin
    w_state_next   = r_state;
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    bus.sysstall   = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_out   = '0;
    bus.done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.sysstall = w_trigger;
        if (w_trigger) w_state_next = StFetch;
      end
      StFetch: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {r_ptr[31:2], 2'b00};
        bus.sysstall = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        bus.sysstall = 1'b1;
        w_state_next = StEmit;
      end
      StEmit: begin
        bus.sysstall = 1'b1;
        if (w_byte == 8'h00) begin
          w_state_next = StDone;
        end else begin
          bus.char_valid = 1'b1;
          bus.char_out   = w_byte;
          if (w_count_inc == CntW'(MAX_LEN)) begin
            w_state_next = StDone;
          end else if (r_ptr[1:0] == 2'd3) begin
            w_state_next = StFetch;
          end
        end
      end
      StDone: begin
        bus.done     = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // The idle stall is combinational from inputs, so force everything quiet in reset.
    if (rst) begin
      bus.mem_rd     = 1'b0;
      bus.mem_addr   = '0;
      bus.sysstall   = 1'b0;
      bus.char_valid = 1'b0;
      bus.char_out   = '0;
      bus.done       = 1'b0;
    end
  end

  if (SIM_PRINT) begin : g_sim_print
    // Mirror emitted characters on the simulation console.
    always_ff @(posedge clk) begin
      if (!rst && bus.char_valid) $write("%c", bus.char_out);
    end
  end

endmodule

// File: tb/tb_syscall_string_printer.sv
// Directed bench for syscall_string_printer; a second instance with MAX_LEN=4
// covers truncation.
module tb_syscall_string_printer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  syscall_string_printer_if ifa ();
  syscall_string_printer_if ifb ();

  syscall_string_printer #(.MAX_LEN(256), .SIM_PRINT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  syscall_string_printer #(.MAX_LEN(4), .SIM_PRINT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  logic        sc = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  bit          sel_b = 1'b0;

  assign ifa.syscall_control = sc;
  assign ifa.v0 = v0;
  assign ifa.a0 = a0;
  assign ifb.syscall_control = sc;
  assign ifb.v0 = v0;
  assign ifb.a0 = a0;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_mem(input logic [31:0] addr);
    return mem.exists(addr) ? mem[addr] : 32'h0;
  endfunction

  // Data memory: read data valid one cycle after the request.
  always @(posedge clk) if (ifa.mem_rd) ifa.mem_data <= rd_mem(ifa.mem_addr);
  always @(posedge clk) if (ifb.mem_rd) ifb.mem_data <= rd_mem(ifb.mem_addr);

  logic        m_sysstall, m_char_valid, m_mem_rd, m_done;
  logic [7:0]  m_char_out;
  logic [31:0] m_mem_addr;
  assign m_sysstall   = sel_b ? ifb.sysstall   : ifa.sysstall;
  assign m_char_valid = sel_b ? ifb.char_valid : ifa.char_valid;
  assign m_char_out   = sel_b ? ifb.char_out   : ifa.char_out;
  assign m_mem_rd     = sel_b ? ifb.mem_rd     : ifa.mem_rd;
  assign m_mem_addr   = sel_b ? ifb.mem_addr   : ifa.mem_addr;
  assign m_done       = sel_b ? ifb.done       : ifa.done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cap_chr[$];
  int          cap_cyc[$];
  logic [31:0] cap_rd[$];
  int          cap_rdcyc[$];
  int          cap_done;
  int          cap_stall_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Triggers a print and records what the selected DUT does, cycle by cycle from T.
  task automatic run_print(input logic [31:0] addr, input int budget);
    int cyc;
    cap_chr.delete(); cap_cyc.delete(); cap_rd.delete(); cap_rdcyc.delete();
    cap_done = -1;
    cap_stall_bad = 0;
    tick();
    sc = 1'b1; v0 = 32'd4; a0 = addr;
    cyc = 0;
    while (cyc <= budget) begin
      @(negedge clk);
      if (m_char_valid) begin cap_chr.push_back(m_char_out); cap_cyc.push_back(cyc); end
      if (m_mem_rd) begin cap_rd.push_back(m_mem_addr); cap_rdcyc.push_back(cyc); end
      if (m_done) begin
        if (m_sysstall) cap_stall_bad++;
        cap_done = cyc;
        break;
      end
      if (!m_sysstall) cap_stall_bad++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    sc = 1'b1; v0 = 32'd4; a0 = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done});
    end
    checks++;
    if ({ifa.char_out, ifa.mem_addr} !== 40'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {ifa.char_out, ifa.mem_addr});
    end
    sc = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 0000",
                         {ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done});
    end
  endtask

  task automatic test_aligned();
    mem[32'h100] = 32'h0000_6948;
    run_print(32'h100, 30);
    checks++;
    if (cap_chr.size() !== 2) begin
      errors++; $display("FAIL hi_count: got %0d expected 2", cap_chr.size());
    end
    checks++;
    if (cap_chr[0] !== 8'h48 || cap_cyc[0] !== 3) begin
      errors++; $display("FAIL hi_char0: got %h@%0d expected 48@3", cap_chr[0], cap_cyc[0]);
    end
    checks++;
    if (cap_chr[1] !== 8'h69 || cap_cyc[1] !== 4) begin
      errors++; $display("FAIL hi_char1: got %h@%0d expected 69@4", cap_chr[1], cap_cyc[1]);
    end
    checks++;
    if (cap_done !== 6) begin
      errors++; $display("FAIL hi_done: got %0d expected 6", cap_done);
    end
    checks++;
    if (cap_stall_bad !== 0) begin
      errors++; $display("FAIL hi_stall: got %0d bad cycles expected 0", cap_stall_bad);
    end
    checks++;
    if (cap_rd.size() !== 1 || cap_rd[0] !== 32'h100 || cap_rdcyc[0] !== 1) begin
      errors++; $display("FAIL hi_fetch: got %0d reads first %h@%0d expected 1 read 100@1",
                         cap_rd.size(), cap_rd[0], cap_rdcyc[0]);
    end
  endtask

  task automatic test_held_syscall();
    int bad;
    bad = 0;
    // sc stays high from the previous print.
    repeat (20) begin
      tick();
      @(negedge clk);
      if (ifa.sysstall || ifa.mem_rd || ifa.char_valid || ifa.done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL held_restart: got %0d active cycles expected 0", bad);
    end
    tick();
    sc = 1'b0;
    mem[32'h400] = 32'h0043_4241;
    run_print(32'h400, 30);
    checks++;
    if (cap_chr.size() !== 3 || cap_chr[0] !== 8'h41 || cap_chr[2] !== 8'h43) begin
      errors++; $display("FAIL rearm_chars: got %0d chars first %h expected 3 chars 41..43",
                         cap_chr.size(), cap_chr[0]);
    end
    checks++;
    if (cap_done !== 7) begin
      errors++; $display("FAIL rearm_done: got %0d expected 7", cap_done);
    end
    tick();
    sc = 1'b0;
  endtask

  task automatic test_wrong_code();
    int bad;
    bad = 0;
    tick();
    sc = 1'b1; v0 = 32'd1; a0 = 32'h100;
    repeat (5) begin
      @(negedge clk);
      if (ifa.sysstall || ifa.mem_rd) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL wrong_code: got %0d active cycles expected 0", bad);
    end
    sc = 1'b0; v0 = '0;
  endtask

  task automatic test_unaligned();
    mem[32'h100] = 32'h4342_0000;
    mem[32'h104] = 32'h0000_0044;
    run_print(32'h102, 30);
    checks++;
    if (cap_chr.size() !== 3 || cap_chr[0] !== 8'h42 || cap_chr[1] !== 8'h43
        || cap_chr[2] !== 8'h44) begin
      errors++; $display("FAIL unal_chars: got %0d chars %h %h %h expected 42 43 44",
                         cap_chr.size(), cap_chr[0], cap_chr[1], cap_chr[2]);
    end
    checks++;
    if (cap_cyc[0] !== 3 || cap_cyc[1] !== 4 || cap_cyc[2] !== 7) begin
      errors++; $display("FAIL unal_timing: got %0d %0d %0d expected 3 4 7",
                         cap_cyc[0], cap_cyc[1], cap_cyc[2]);
    end
    checks++;
    if (cap_rd.size() !== 2 || cap_rd[0] !== 32'h100 || cap_rd[1] !== 32'h104
        || cap_rdcyc[1] !== 5) begin
      errors++; $display("FAIL unal_fetch: got %0d reads %h %h@%0d expected 100 104@5",
                         cap_rd.size(), cap_rd[0], cap_rd[1], cap_rdcyc[1]);
    end
    checks++;
    if (cap_done !== 9) begin
      errors++; $display("FAIL unal_done: got %0d expected 9", cap_done);
    end
    tick();
    sc = 1'b0;
  endtask

  task automatic test_empty();
    mem[32'h300] = 32'h5A5A_5A00;
    run_print(32'h300, 30);
    checks++;
    if (cap_chr.size() !== 0) begin
      errors++; $display("FAIL empty_chars: got %0d expected 0", cap_chr.size());
    end
    checks++;
    if (cap_done !== 4) begin
      errors++; $display("FAIL empty_done: got %0d expected 4", cap_done);
    end
    checks++;
    if (cap_rd.size() !== 1) begin
      errors++; $display("FAIL empty_reads: got %0d expected 1", cap_rd.size());
    end
    tick();
    sc = 1'b0;
  endtask

  task automatic test_truncation();
    mem[32'h200] = 32'h4443_4241;
    mem[32'h204] = 32'h4847_4645;
    sel_b = 1'b1;
    run_print(32'h200, 30);
    checks++;
    if (cap_chr.size() !== 4 || cap_chr[0] !== 8'h41 || cap_chr[3] !== 8'h44) begin
      errors++; $display("FAIL trunc_chars: got %0d chars first %h last %h expected 4, 41..44",
                         cap_chr.size(), cap_chr[0], cap_chr[3]);
    end
    checks++;
    if (cap_done !== 7) begin
      errors++; $display("FAIL trunc_done: got %0d expected 7", cap_done);
    end
    checks++;
    if (cap_rd.size() !== 1) begin
      errors++; $display("FAIL trunc_reads: got %0d expected 1", cap_rd.size());
    end
    sel_b = 1'b0;
    tick();
    sc = 1'b0;
    // Let the full-length instance finish the same string.
    repeat (15) tick();
  endtask

  task automatic test_reset_mid_print();
    int bad;
    mem[32'h100] = 32'h0000_6948;
    tick();
    sc = 1'b1; v0 = 32'd4; a0 = 32'h100;
    repeat (4) tick();
    // Now in the second EMIT cycle.
    rst = 1'b1;
    sc = 1'b0;
    #1;
    checks++;
    if ({ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done} !== 4'b0
        || ifa.char_out !== 8'h0) begin
      errors++; $display("FAIL midreset_outputs: got %b/%h expected 0000/00",
                         {ifa.sysstall, ifa.mem_rd, ifa.char_valid, ifa.done}, ifa.char_out);
    end
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.done || ifa.char_valid || ifa.mem_rd) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
    end
    mem[32'h600] = 32'h0000_0037;
    run_print(32'h600, 30);
    checks++;
    if (cap_chr.size() !== 1 || cap_chr[0] !== 8'h37 || cap_done !== 5) begin
      errors++; $display("FAIL midreset_reprint: got %0d chars %h done %0d expected 1 37 done 5",
                         cap_chr.size(), cap_chr[0], cap_done);
    end
    tick();
    sc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_held_syscall();
    test_wrong_code();
    test_unaligned();
    test_empty();
    test_truncation();
    test_reset_mid_print();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syscall_string_printer.md
# syscall_string_printer

Companion stage to the syscall unit that services the print-string syscall (v0 = 4). On a qualifying syscall it latches the string pointer from a0, fetches words from the data memory read port, and emits the NUL-terminated string one byte per cycle on a character output. It holds the pipeline via `sysstall` until the string is finished, so the syscall unit evaluates the instruction only once the print is complete.

## Interface
- `MAX_LEN`, 256: maximum characters emitted per syscall; terminates the string if no NUL is found.
- `SIM_PRINT`, 1: when 1, each emitted character is also written to the simulation console with `$write("%c")`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `syscall_control`  in  1  syscall instruction present in this stage.
- `v0`  in  32  syscall code.
- `a0`  in  32  byte address of the string.
- `mem_rd`  out  1  data memory read request.
- `mem_addr`  out  32  word-aligned read address: pointer bits [31:2] concatenated with 2'b00.
- `mem_data`  in  32  read data, valid exactly one cycle after `mem_rd`.
- `sysstall`  out  1  pipeline stall request.
- `char_valid`  out  1  `char_out` holds a character this cycle.
- `char_out`  out  8  emitted character.
- `done`  out  1  one-cycle pulse at the end of a print.

## Operation
- **Registers**
  - `state`.
  - `ptr[31:0]`: byte pointer.
  - `word[31:0]`: fetched word.
  - `count`: characters emitted, width clog2(MAX_LEN+1).
  - `armed`: re-trigger guard.
- **Trigger**: `syscall_control`=1 and `v0`=4 and `armed`=1, sampled in IDLE.
  - At that edge, `ptr`←`a0`, `count`←0, `armed`←0.
  - Any other `v0` value is ignored.
- **IDLE**: all outputs low, except `sysstall`, which is high combinationally in the cycle the trigger condition is true.
  - `armed`←1 whenever `syscall_control`=0.
- **FETCH**: `mem_rd`=1, `mem_addr`={ptr[31:2],2'b00}. Next state: WAIT.
- **WAIT**: at the end of the cycle, `word`←`mem_data`. Next state: EMIT.
- **EMIT**: byte b = `word`[8·ptr[1:0]+7 : 8·ptr[1:0]] (little-endian).
  - If b = 0x00: next state DONE, nothing emitted.
  - Otherwise: `char_valid`=1 and `char_out`=b. Then `ptr`←`ptr`+1 and `count`←`count`+1.
    - If the new count equals `MAX_LEN`: next state DONE.
    - Else if the old ptr[1:0] = 3: next state FETCH.
    - Else: stay in EMIT.
- **DONE**: `done`=1 and `sysstall`=0 for one cycle. Next state: IDLE.
- **Held syscall**: `armed` stays 0 until `syscall_control` drops. A syscall still held after DONE therefore does not restart the print.
- **Latched inputs**: `v0`/`a0` changes after the trigger are ignored; only the value latched at the trigger is used.
- **Pointer wrap**: `ptr` wraps from 0xFFFFFFFF to 0x00000000 modulo 2^32.

## Timing
- **Reset values**: state=IDLE, `armed`=1, ptr=0, word=0, count=0. All outputs are 0 while `rst`=1.
- **Stall**: `sysstall`=1 from the trigger cycle through every FETCH, WAIT and EMIT cycle, and 0 in DONE and IDLE.
- **Fetch cost**: 2 cycles per word (FETCH + WAIT), then 1 cycle per byte examined.
- **Aligned string of N characters plus NUL** (trigger at cycle T):
  - FETCH at T+1, first character at T+3.
  - Total cycles from trigger to `done` = 3 + N + 2·⌊N/4⌋ + 1.
  - Example: "Hi" gives `done` at T+6.
- **Unaligned start**: the first word is partial; bytes below a0[1:0] are never examined.
- **Reset mid-print**: immediate return to IDLE with all outputs low. No further characters or `done` are produced.
- **Truncation**: reaching `MAX_LEN` without a NUL ends the print normally (`done` pulses), and the next byte is not fetched.

## Test plan
- **Aligned string**: memory word 0x100 = 0x00006948 ("Hi\0"); trigger v0=4, a0=0x100 at T.
  - `char_out` = 0x48 at T+3, 0x69 at T+4; `done` at T+6; `sysstall` high T..T+5.
- **Unaligned, word-crossing**: a0=0x102; word 0x100 = 0x43420000, word 0x104 = 0x00000044.
  - Emits 0x42, 0x43, then FETCH of 0x104 with two bubble cycles, then 0x44; `done` follows the NUL.
- **Empty string**: first byte 0x00.
  - No `char_valid`; `done` at T+4; `mem_rd` asserted exactly once.
- **Truncation**: `MAX_LEN`=4, eight non-zero bytes.
  - Exactly 4 characters emitted, `done` the next cycle, only one `mem_rd`.
- **Held syscall and wrong code**: `syscall_control` held high 20 cycles after `done` gives no restart. Dropping it for one cycle then reasserting starts a new print. v0=1 with `syscall_control`=1 gives `sysstall`=0 and no `mem_rd`.
- **Reset mid-print**: assert `rst` on the second EMIT cycle.
  - All outputs go 0 immediately and no `done` is produced.
  - After release, a new trigger prints correctly from its own a0.
